// File: rtl/alu_seq.sv
// Sequential ALU for the execute stage: single-cycle ops plus bit-serial sll/zfr, valid/ready on both sides.
// Optional signed-overflow flag for add/sub is built only when ALU_SEQ_OVF_EN is defined.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sll_q, sll_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] sum, diff, op_res, shifted, iter_res;
  logic             op_ill, accept, is_shift;

  assign sum      = a + b;
  assign diff     = a - b;
  assign accept   = in_valid && (state_q == IDLE);
  assign is_shift = (alucontrol == 4'b0100) || (alucontrol == 4'b0101);

  // Full-width result; also the answer for sll/zfr when shamt is zero
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (alucontrol)
      4'b0000: op_res = a & b;
      4'b0001: op_res = a | b;
      4'b0010: op_res = sum;
      4'b0110: op_res = b;
      4'b1010: op_res = diff;
      4'b1011: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0100: op_res = b << shamt;
      4'b0101: op_res = a & ({WIDTH{1'b1}} << shamt);
      default: op_ill = 1'b1;
    endcase
  end

  // acc holds the shifting operand (sll) or the shifting mask (zfr)
  assign shifted  = acc_q << 1;
  assign iter_res = sll_q ? shifted : (a_q & shifted);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    sll_d     = sll_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            state_d   = ITER;
            cnt_d     = shamt;
            sll_d     = (alucontrol == 4'b0100);
            acc_d     = (alucontrol == 4'b0100) ? b : '1;
            a_d       = a;
            illegal_d = 1'b0;
          end else begin
            state_d   = DONE;
            result_d  = op_res;
            zero_d    = ~|op_res;
            illegal_d = op_ill;
          end
        end
      end
      ITER: begin
        acc_d = shifted;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d  = DONE;
          result_d = iter_res;
          zero_d   = ~|iter_res;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      sll_q     <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      sll_q     <= sll_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q, ovf_d, op_ovf;

  always_comb begin
    op_ovf = 1'b0;
    if (alucontrol == 4'b0010)
      op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (alucontrol == 4'b1010)
      op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (accept) ovf_d = op_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, randomized ops against an arithmetic model,
// output hold, mid-iteration reset and back-to-back throughput.
module tb_alu_seq;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready;
  logic          zero, illegal, overflow;
  logic [3:0]    alucontrol;
  logic [W-1:0]  a, b, result;
  logic [SW-1:0] shamt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .SHW(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .overflow(overflow)
  );

  // Reference model from the operation table, using 64-bit arithmetic
  function automatic logic [W-1:0] m_res(input logic [3:0] op, input logic [W-1:0] x, y, input int sh);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint one = 1;
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return W'(ux + uy);
      4'd6:  return y;
      4'd10: return W'(ux - uy);
      4'd11: return (sx < sy) ? 1 : 0;
      4'd4:  return W'(uy << sh);
      4'd5:  return x & W'(~((one << sh) - 1));
      default: return 0;
    endcase
  endfunction

  function automatic logic m_ill(input logic [3:0] op);
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd10, 4'd11, 4'd4, 4'd5});
  endfunction

  function automatic logic m_ovf(input logic [3:0] op, input logic [W-1:0] x, y);
`ifdef ALU_SEQ_OVF_EN
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r;
    if (op == 4'd2)       r = sx + sy;
    else if (op == 4'd10) r = sx - sy;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_lat(input logic [3:0] op, input int sh);
    return (op == 4'd4 || op == 4'd5) ? 1 + sh : 1;
  endfunction

  // Drives one transaction and reports observations; comparisons live in the callers
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, bv, input logic [SW-1:0] sv,
                        output int lat, output logic [W-1:0] r, output logic z, il, ov,
                        output logic busy_bad, output logic rdy_after);
    @(negedge clk);
    in_valid = 1'b1; alucontrol = op; a = av; b = bv; shamt = sv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alucontrol = 4'($urandom); a = $urandom; b = $urandom; shamt = SW'($urandom);
    lat = 1; busy_bad = 1'b0;
    while (!out_valid && lat < W + 8) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) busy_bad = 1'b1;
    r = result; z = zero; il = illegal; ov = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rdy_after = in_ready;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alucontrol = '0; a = '0; b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({in_ready, out_valid, zero, illegal, overflow} !== 5'b10100)
      $display("FAIL reset_flags: got %b want 10100", {in_ready, out_valid, zero, illegal, overflow});
    else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed;
    int lat; logic [W-1:0] r; logic z, il, ov, bb, ra;
    run_op(4'd2, 32'd7, 32'd5, 0, lat, r, z, il, ov, bb, ra);
    n_checks++; if ({lat, r, z, il} !== {32'd1, 32'd12, 1'b0, 1'b0})
      $display("FAIL add7_5: lat=%0d r=%h z=%b il=%b want lat=1 r=0000000c z=0 il=0", lat, r, z, il);
    else n_pass++;
    run_op(4'd10, 32'd9, 32'd9, 0, lat, r, z, il, ov, bb, ra);
    n_checks++; if ({r, z} !== {32'd0, 1'b1}) $display("FAIL sub_beq: r=%h z=%b want 0 1", r, z); else n_pass++;
    run_op(4'd11, 32'hFFFF_FFFF, 32'd1, 0, lat, r, z, il, ov, bb, ra);
    n_checks++; if (r !== 32'd1) $display("FAIL slt_neg: r=%h want 1", r); else n_pass++;
    run_op(4'd4, 32'h0, 32'h1, 5'd31, lat, r, z, il, ov, bb, ra);
    n_checks++; if ({lat, r, bb} !== {32'd32, 32'h8000_0000, 1'b0})
      $display("FAIL sll31: lat=%0d r=%h busy_bad=%b want 32 80000000 0", lat, r, bb);
    else n_pass++;
    run_op(4'd5, 32'hFFFF_FFFF, 32'h0, 5'd4, lat, r, z, il, ov, bb, ra);
    n_checks++; if ({lat, r} !== {32'd5, 32'hFFFF_FFF0})
      $display("FAIL zfr4: lat=%0d r=%h want 5 fffffff0", lat, r);
    else n_pass++;
    run_op(4'd5, 32'h1234_5678, 32'h0, 5'd0, lat, r, z, il, ov, bb, ra);
    n_checks++; if ({lat, r} !== {32'd1, 32'h1234_5678})
      $display("FAIL zfr0: lat=%0d r=%h want 1 12345678", lat, r);
    else n_pass++;
    run_op(4'd2, 32'h7FFF_FFFF, 32'd1, 0, lat, r, z, il, ov, bb, ra);
    n_checks++; if ({r, ov} !== {32'h8000_0000, m_ovf(4'd2, 32'h7FFF_FFFF, 32'd1)})
      $display("FAIL add_ovf: r=%h ov=%b want 80000000 %b", r, ov, m_ovf(4'd2, 32'h7FFF_FFFF, 32'd1));
    else n_pass++;
    run_op(4'd10, 32'h8000_0000, 32'd1, 0, lat, r, z, il, ov, bb, ra);
    n_checks++; if ({r, ov} !== {32'h7FFF_FFFF, m_ovf(4'd10, 32'h8000_0000, 32'd1)})
      $display("FAIL sub_ovf: r=%h ov=%b want 7fffffff %b", r, ov, m_ovf(4'd10, 32'h8000_0000, 32'd1));
    else n_pass++;
  endtask

  task automatic test_random;
    int lat, sh; logic [W-1:0] r, av, bv; logic z, il, ov, bb, ra; logic [3:0] op;
    logic [3:0] ops [9] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd10, 4'd11, 4'd4, 4'd5, 4'd0};
    for (int k = 0; k < 40; k++) begin
      op = (k % 9 == 8) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      av = $urandom; bv = $urandom;
      if (k % 7 == 0) bv = av;
      sh = (k % 5 == 0) ? 0 : (k % 5 == 1) ? 31 : int'($urandom_range(1, 31));
      run_op(op, av, bv, SW'(sh), lat, r, z, il, ov, bb, ra);
      n_checks++; if (r !== m_res(op, av, bv, sh))
        $display("FAIL rand_res op=%h: got %h want %h", op, r, m_res(op, av, bv, sh));
      else n_pass++;
      n_checks++; if (z !== (m_res(op, av, bv, sh) == 0))
        $display("FAIL rand_zero op=%h: got %b want %b", op, z, m_res(op, av, bv, sh) == 0);
      else n_pass++;
      n_checks++; if (il !== m_ill(op)) $display("FAIL rand_ill op=%h: got %b want %b", op, il, m_ill(op)); else n_pass++;
      n_checks++; if (ov !== m_ovf(op, av, bv))
        $display("FAIL rand_ovf op=%h: got %b want %b", op, ov, m_ovf(op, av, bv));
      else n_pass++;
      n_checks++; if (lat !== m_lat(op, sh)) $display("FAIL rand_lat op=%h: got %0d want %0d", op, lat, m_lat(op, sh)); else n_pass++;
      n_checks++; if ({bb, ra} !== 2'b01) $display("FAIL rand_ready op=%h: busy_bad=%b ready_after=%b want 0 1", op, bb, ra); else n_pass++;
    end
  endtask

  task automatic test_hold;
    int wait_cyc = 0;
    @(negedge clk);
    in_valid = 1'b1; alucontrol = 4'b0111; a = 32'hDEAD_BEEF; b = 32'h1; shamt = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && wait_cyc < 10) begin @(posedge clk); #1; wait_cyc++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({out_valid, in_ready, illegal, zero, result} !== {4'b1011, 32'h0})
        $display("FAIL hold_%0d: v=%b rdy=%b il=%b z=%b r=%h want 1 0 1 1 0", i, out_valid, in_ready, illegal, zero, result);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL hold_release: rdy=%b v=%b want 1 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_iter;
    @(negedge clk);
    in_valid = 1'b1; alucontrol = 4'd4; a = '0; b = 32'h5; shamt = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({out_valid, in_ready, zero, illegal, overflow, result} !== {5'b01100, 32'h0})
      $display("FAIL reset_iter: v=%b rdy=%b z=%b il=%b ov=%b r=%h want 0 1 1 0 0 0",
               out_valid, in_ready, zero, illegal, overflow, result);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_iter_dropped: v=%b want 0", out_valid); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int done_cnt = 0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; alucontrol = 4'd2; a = 32'd3; b = 32'd4; shamt = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        done_cnt++;
        n_checks++; if (result !== 32'd7) $display("FAIL b2b_res: got %h want 7", result); else n_pass++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (done_cnt !== 10) $display("FAIL b2b_rate: got %0d results want 10", done_cnt); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid_iter();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
